nanci_phase_ctrl: RTL and testbench

Phase sequencer for the Nanci PE mesh. On a start request it drives every PE in lock-step through memory clear, then a fixed number of sort/compute/shift rounds, and reports completion. It broadcasts phase enables and the neighbour-port select (l/r/u/d) to the whole array. It sits between the top-level host interface and the SQRT_N×SQRT_N PE grid, replacing free-running PE phase counters with one central schedule.

---
 rtl/nanci_phase_ctrl.sv | 128 ++++++++++++
 tb/tb_nanci_phase_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/nanci_phase_ctrl.sv
// Central phase sequencer for the Nanci PE mesh: CLEAR, then ROUNDS x (SORT, COMPUTE, SHIFT_R, SHIFT_D), then DONE.
// Optional abort path enabled by defining NANCI_CTRL_ABORT_EN (adds i_abort / o_aborted).
module nanci_phase_ctrl #(
  parameter int SQRT_N         = 4,
  parameter int SORT_CYCLES    = 1,
  parameter int COMPUTE_CYCLES = 1,
  parameter int ROUNDS         = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_stall,
`ifdef NANCI_CTRL_ABORT_EN
  input  logic                         i_abort,
  output logic                         o_aborted,
`endif
  output logic                         o_busy,
  output logic                         o_done,
  output logic [2:0]                   o_phase,
  output logic [1:0]                   o_dir,
  output logic                         o_mem_clr,
  output logic                         o_sort_en,
  output logic                         o_compute_en,
  output logic                         o_shift_en,
  output logic [$clog2(ROUNDS+1)-1:0]  o_round
);
  localparam int RW   = $clog2(ROUNDS + 1);
  localparam int M1   = (SORT_CYCLES > COMPUTE_CYCLES) ? SORT_CYCLES : COMPUTE_CYCLES;
  localparam int MAXL = (M1 > SQRT_N) ? M1 : SQRT_N;
  localparam int CW   = $clog2(MAXL + 1);
  localparam bit HAS_SHIFT = (SQRT_N > 1);
  localparam logic [CW-1:0] SORT_LAST  = CW'(SORT_CYCLES - 1);
  localparam logic [CW-1:0] COMP_LAST  = CW'(COMPUTE_CYCLES - 1);
  localparam logic [CW-1:0] SHIFT_LAST = CW'(HAS_SHIFT ? SQRT_N - 2 : 0);
  localparam logic [RW-1:0] ROUND_LAST = RW'(ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CLEAR = 3'd1, S_SORT = 3'd2, S_COMP = 3'd3,
    S_SHR  = 3'd4, S_SHD   = 3'd5, S_DONE = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] round_q, round_d;
  logic          busy_q, busy_d;
  logic [1:0]    dir_q, dir_d;
  logic          aborted_q, aborted_d;
  logic          stall_hold;
  logic          last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      round_q   <= '0;
      busy_q    <= 1'b0;
      dir_q     <= 2'b00;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      round_q   <= round_d;
      busy_q    <= busy_d;
      dir_q     <= dir_d;
      aborted_q <= aborted_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    round_d    = round_q;
    aborted_d  = 1'b0;
    stall_hold = i_stall && (state_q inside {S_SORT, S_COMP, S_SHR, S_SHD});
    case (state_q)
      S_SORT:       last = (cnt_q == SORT_LAST);
      S_COMP:       last = (cnt_q == COMP_LAST);
      S_SHR, S_SHD: last = (cnt_q == SHIFT_LAST);
      default:      last = 1'b0;
    endcase
    if (!stall_hold) begin
      case (state_q)
        S_IDLE:  if (i_start) state_d = S_CLEAR;
        S_CLEAR: state_d = S_SORT;
        S_SORT:  if (last) state_d = S_COMP;
        S_COMP:  if (last) state_d = HAS_SHIFT ? S_SHR :
                                     ((round_q == ROUND_LAST) ? S_DONE : S_SORT);
        S_SHR:   if (last) state_d = S_SHD;
        S_SHD:   if (last) state_d = (round_q == ROUND_LAST) ? S_DONE : S_SORT;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
      // A round ends where the last phase of the round exits.
      if (last && (state_q == S_SHD || (state_q == S_COMP && !HAS_SHIFT)))
        round_d = round_q + 1'b1;
    end
`ifdef NANCI_CTRL_ABORT_EN
    if (i_abort && state_q != S_IDLE && state_q != S_DONE) begin
      state_d   = S_IDLE;
      aborted_d = 1'b1;
    end
`endif
    if (stall_hold && state_d == state_q)
      cnt_d = cnt_q;
    else if (state_d != state_q || state_q == S_IDLE)
      cnt_d = '0;
    else
      cnt_d = cnt_q + 1'b1;
    if (state_d == S_IDLE) round_d = '0;
    busy_d = (state_d != S_IDLE);
    dir_d  = (state_d == S_SHR) ? 2'b01 : (state_d == S_SHD) ? 2'b11 : 2'b00;
  end

  always_comb begin
    o_phase      = state_q;
    o_busy       = busy_q;
    o_dir        = dir_q;
    o_round      = round_q;
    o_done       = (state_q == S_DONE);
    // CLEAR cannot be stalled, so its strobe is never suppressed.
    o_mem_clr    = (state_q == S_CLEAR);
    o_sort_en    = (state_q == S_SORT) && !i_stall;
    o_compute_en = (state_q == S_COMP) && !i_stall;
    o_shift_en   = (state_q == S_SHR || state_q == S_SHD) && !i_stall;
`ifdef NANCI_CTRL_ABORT_EN
    o_aborted    = aborted_q;
`endif
  end
endmodule

// File: tb/tb_nanci_phase_ctrl.sv
// Randomized bench for nanci_phase_ctrl: three parameterizations checked cycle by cycle
// against a phase-schedule list built from the phase lengths.
module tb_nanci_phase_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic stall = 1'b0;
  logic st_a = 1'b0, st_b = 1'b0, st_c = 1'b0;
  int tests = 0, fails = 0;

  logic       a_busy, a_done, a_clr, a_sort, a_comp, a_shift; logic [2:0] a_phase; logic [1:0] a_dir; logic [0:0] a_round;
  logic       b_busy, b_done, b_clr, b_sort, b_comp, b_shift; logic [2:0] b_phase; logic [1:0] b_dir; logic [1:0] b_round;
  logic       c_busy, c_done, c_clr, c_sort, c_comp, c_shift; logic [2:0] c_phase; logic [1:0] c_dir; logic [1:0] c_round;
`ifdef NANCI_CTRL_ABORT_EN
  logic ab = 1'b0;
  logic a_abd, b_abd, c_abd;
`endif

  always #5 clk = ~clk;

  nanci_phase_ctrl #(.SQRT_N(4), .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .ROUNDS(1)) u_a (
    .clk(clk), .rst(rst), .i_start(st_a), .i_stall(stall),
`ifdef NANCI_CTRL_ABORT_EN
    .i_abort(ab), .o_aborted(a_abd),
`endif
    .o_busy(a_busy), .o_done(a_done), .o_phase(a_phase), .o_dir(a_dir), .o_mem_clr(a_clr),
    .o_sort_en(a_sort), .o_compute_en(a_comp), .o_shift_en(a_shift), .o_round(a_round));

  nanci_phase_ctrl #(.SQRT_N(1), .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .ROUNDS(2)) u_b (
    .clk(clk), .rst(rst), .i_start(st_b), .i_stall(stall),
`ifdef NANCI_CTRL_ABORT_EN
    .i_abort(ab), .o_aborted(b_abd),
`endif
    .o_busy(b_busy), .o_done(b_done), .o_phase(b_phase), .o_dir(b_dir), .o_mem_clr(b_clr),
    .o_sort_en(b_sort), .o_compute_en(b_comp), .o_shift_en(b_shift), .o_round(b_round));

  nanci_phase_ctrl #(.SQRT_N(4), .SORT_CYCLES(1), .COMPUTE_CYCLES(1), .ROUNDS(2)) u_c (
    .clk(clk), .rst(rst), .i_start(st_c), .i_stall(stall),
`ifdef NANCI_CTRL_ABORT_EN
    .i_abort(ab), .o_aborted(c_abd),
`endif
    .o_busy(c_busy), .o_done(c_done), .o_phase(c_phase), .o_dir(c_dir), .o_mem_clr(c_clr),
    .o_sort_en(c_sort), .o_compute_en(c_comp), .o_shift_en(c_shift), .o_round(c_round));

  // Expected output bundle for a phase code, round and whether the schedule is frozen.
  function automatic logic [14:0] exp_vec(input int ph, input int rnd, input bit hold);
    logic [1:0] dir;
    dir = (ph == 4) ? 2'b01 : (ph == 5) ? 2'b11 : 2'b00;
    return {3'(ph), 1'(ph != 0), 1'(ph == 6), dir, 1'(ph == 1),
            1'(ph == 2 && !hold), 1'(ph == 3 && !hold), 1'((ph == 4 || ph == 5) && !hold), 4'(rnd)};
  endfunction

  function automatic logic [14:0] obs_vec(input int sel);
    case (sel)
      0:       return {a_phase, a_busy, a_done, a_dir, a_clr, a_sort, a_comp, a_shift, 4'(a_round)};
      1:       return {b_phase, b_busy, b_done, b_dir, b_clr, b_sort, b_comp, b_shift, 4'(b_round)};
      default: return {c_phase, c_busy, c_done, c_dir, c_clr, c_sort, c_comp, c_shift, 4'(c_round)};
    endcase
  endfunction

  task automatic set_start(input int sel, input logic v);
    st_a = (sel == 0) ? v : 1'b0;
    st_b = (sel == 1) ? v : 1'b0;
    st_c = (sel == 2) ? v : 1'b0;
  endtask

  task automatic test_reset;
    for (int s = 0; s < 3; s++) begin
      tests++;
      if (obs_vec(s) !== exp_vec(0, 0, 1'b0)) begin
        fails++;
        $display("FAIL reset dut%0d got %h want %h", s, obs_vec(s), exp_vec(0, 0, 1'b0));
      end
    end
  endtask

  // Runs one start-to-IDLE sequence on DUT sel, comparing every cycle against the schedule.
  task automatic test_run(input int sel, input int n, input int sc, input int cc, input int r,
                          input int pct, input int sf, input int sl, input bit noise,
                          input int exp_done, input string name);
    int ph_q[$]; int rd_q[$];
    int idx, cyc, done_cyc, ph;
    bit stl, hold;
    logic [14:0] e, o;
    ph_q.push_back(1); rd_q.push_back(0);
    for (int rr = 0; rr < r; rr++) begin
      for (int k = 0; k < sc; k++) begin ph_q.push_back(2); rd_q.push_back(rr); end
      for (int k = 0; k < cc; k++) begin ph_q.push_back(3); rd_q.push_back(rr); end
      for (int k = 0; k < n - 1; k++) begin ph_q.push_back(4); rd_q.push_back(rr); end
      for (int k = 0; k < n - 1; k++) begin ph_q.push_back(5); rd_q.push_back(rr); end
    end
    ph_q.push_back(6); rd_q.push_back(r);

    @(posedge clk); #1;
    set_start(sel, 1'b1);
    stall = ($urandom_range(99) < pct);
    @(negedge clk);
    tests++;
    if (obs_vec(sel) !== exp_vec(0, 0, 1'b0)) begin
      fails++;
      $display("FAIL %s idle0 got %h want %h", name, obs_vec(sel), exp_vec(0, 0, 1'b0));
    end
    @(posedge clk); #1;
    idx = 0; cyc = 1; done_cyc = -1;
    while (idx < ph_q.size() && cyc < 300) begin
      stl = ($urandom_range(99) < pct) || (cyc >= sf && cyc < sf + sl);
      stall = stl;
      set_start(sel, noise ? 1'($urandom_range(1)) : 1'b0);
      @(negedge clk);
      ph = ph_q[idx];
      hold = stl && ph >= 2 && ph <= 5;
      e = exp_vec(ph, rd_q[idx], hold);
      o = obs_vec(sel);
      tests++;
      if (o !== e) begin
        fails++;
        $display("FAIL %s cyc %0d got %h want %h", name, cyc, o, e);
      end
      if (ph == 6) done_cyc = cyc;
      if (!hold) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    tests++;
    if (idx < ph_q.size()) begin
      fails++;
      $display("FAIL %s timeout idx %0d want %0d", name, idx, ph_q.size());
    end
    set_start(sel, 1'b0);
    stall = 1'b0;
    @(negedge clk);
    tests++;
    if (obs_vec(sel) !== exp_vec(0, 0, 1'b0)) begin
      fails++;
      $display("FAIL %s final idle got %h want %h", name, obs_vec(sel), exp_vec(0, 0, 1'b0));
    end
    if (exp_done >= 0) begin
      tests++;
      if (done_cyc != exp_done) begin
        fails++;
        $display("FAIL %s done cycle got %0d want %0d", name, done_cyc, exp_done);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    @(posedge clk); #1;
    st_a = 1'b1;
    @(posedge clk); #1;
    st_a = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    tests++;
    if (a_phase !== 3'd0 || a_busy !== 1'b0) begin
      fails++;
      $display("FAIL async_rst got phase %0d busy %b want 0 0", a_phase, a_busy);
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      tests++;
      if (a_done !== 1'b0 || a_phase !== 3'd0) begin
        fails++;
        $display("FAIL rst_no_done k %0d got done %b phase %0d want 0 0", k, a_done, a_phase);
      end
    end
  endtask

`ifdef NANCI_CTRL_ABORT_EN
  task automatic test_abort(input bit with_stall);
    @(posedge clk); #1;
    st_a = 1'b1;
    @(posedge clk); #1;
    st_a = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    ab = 1'b1; stall = with_stall;
    @(posedge clk); #1;
    ab = 1'b0; stall = 1'b0;
    @(negedge clk);
    tests++;
    if ({a_phase, a_abd, a_done, a_busy} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort stall=%b got phase %0d abd %b done %b busy %b want 0 1 0 0",
               with_stall, a_phase, a_abd, a_done, a_busy);
    end
    @(negedge clk);
    tests++;
    if ({a_abd, a_done} !== 2'b00) begin
      fails++;
      $display("FAIL abort_pulse got abd %b done %b want 0 0", a_abd, a_done);
    end
  endtask
`endif

  initial begin
    #2;
    test_reset;
    @(negedge clk);
    rst = 1'b1;
    test_run(0, 4, 1, 1, 1, 0, 0, 0, 1'b0, 10, "default_seq");
    test_run(2, 4, 1, 1, 2, 0, 0, 0, 1'b0, 18, "rounds2");
    test_run(1, 1, 1, 1, 2, 0, 0, 0, 1'b0, 6, "sqrt1");
    test_run(0, 4, 1, 1, 1, 0, 5, 3, 1'b0, 13, "stall_shift");
    test_run(0, 4, 1, 1, 1, 0, 0, 0, 1'b1, 10, "restart_ignored");
    for (int i = 0; i < 6; i++) begin
      test_run(0, 4, 1, 1, 1, 30, 0, 0, 1'b1, -1, "rand_a");
      test_run(1, 1, 1, 1, 2, 30, 0, 0, 1'b1, -1, "rand_b");
      test_run(2, 4, 1, 1, 2, 30, 0, 0, 1'b1, -1, "rand_c");
    end
    test_run(0, 4, 1, 1, 1, 0, 0, 0, 1'b0, 10, "back_to_back");
    test_reset_mid_run;
`ifdef NANCI_CTRL_ABORT_EN
    test_abort(1'b0);
    test_abort(1'b1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
